// File: rtl/pll_reset_sequencer.sv
// PLL lock qualification and staggered domain-reset release.
// Holds the PLL in reset on power-up/timeout, then releases rst_out bits in index order.
module pll_reset_sequencer #(
    parameter int NUM_RESETS         = 3,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 1024,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int RELEASE_GAP        = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_unlocked,
    output logic                  pll_reset_req,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_lost_cnt,
    output logic [7:0]            timeout_cnt
);
    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    localparam int CNT_MAX =
        (PLL_RST_CYCLES > LOCK_TIMEOUT)
            ? ((PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES)
            : ((LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES);
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_W = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
    localparam int IDX_W = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(RELEASE_GAP - 1);
    // idx value whose next step clears the top bit
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RESETS - 2);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap;
    logic [IDX_W-1:0] idx;
    logic [1:0]       sync_pipe;
    logic             locked_s;

    assign locked_s = ~sync_pipe[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_pipe     <= 2'b11;
            state         <= S_PLL_RST;
            cnt           <= '0;
            gap           <= '0;
            idx           <= '0;
            pll_reset_req <= 1'b1;
            rst_out       <= '1;
            ready         <= 1'b0;
            lock_lost_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            sync_pipe <= {sync_pipe[0], pll_unlocked};
            case (state)
                S_PLL_RST: begin
                    if (cnt == PLL_RST_LAST) begin
                        state         <= S_WAIT_LOCK;
                        cnt           <= '0;
                        pll_reset_req <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    rst_out <= '1;
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state         <= S_PLL_RST;
                        cnt           <= '0;
                        pll_reset_req <= 1'b1;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        // rst_out is a thermometer, so a left shift clears the lowest set bit
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                        idx     <= '0;
                        gap     <= '0;
                        if (NUM_RESETS == 1) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!locked_s) begin
                        // lock loss wins over a release step due on the same edge
                        rst_out <= '1;
                        ready   <= 1'b0;
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
                    end else if (state == S_RELEASE) begin
                        if (gap == GAP_LAST) begin
                            rst_out <= rst_out << 1;
                            idx     <= idx + IDX_W'(1);
                            gap     <= '0;
                            if (idx == IDX_LAST) begin
                                state <= S_RUN;
                                ready <= 1'b1;
                            end
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state         <= S_PLL_RST;
                    cnt           <= '0;
                    pll_reset_req <= 1'b1;
                    rst_out       <= '1;
                    ready         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued with the edge
// index at which they must hold and compared on the following falling edge.
module tb_pll_reset_sequencer;
    localparam int NR = 3;
    localparam int SEL_RST = 0, SEL_RDY = 1, SEL_REQ = 2, SEL_LL = 3, SEL_TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pll_unlocked;
    logic          pll_reset_req;
    logic [NR-1:0] rst_out;
    logic          ready;
    logic [7:0]    lock_lost_cnt;
    logic [7:0]    timeout_cnt;

    pll_reset_sequencer #(
        .NUM_RESETS(NR), .PLL_RST_CYCLES(16), .LOCK_TIMEOUT(1024),
        .LOCK_STABLE_CYCLES(64), .RELEASE_GAP(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_unlocked(pll_unlocked),
        .pll_reset_req(pll_reset_req), .rst_out(rst_out), .ready(ready),
        .lock_lost_cnt(lock_lost_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_run = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input int sel);
        case (sel)
            SEL_RST: obs_of = 32'(rst_out);
            SEL_RDY: obs_of = 32'(ready);
            SEL_REQ: obs_of = 32'(pll_reset_req);
            SEL_LL:  obs_of = 32'(lock_lost_cnt);
            default: obs_of = 32'(timeout_cnt);
        endcase
    endfunction

    task automatic push(input int at, input int sel, input int v, input string tag);
        sb_t e;
        e.cyc = at; e.sel = sel; e.val = 32'(v); e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_reset_vals(input int at, input string tag);
        push(at, SEL_RST, 7, {tag, "_rst"});
        push(at, SEL_REQ, 1, {tag, "_req"});
        push(at, SEL_RDY, 0, {tag, "_rdy"});
        push(at, SEL_LL,  0, {tag, "_ll"});
        push(at, SEL_TO,  0, {tag, "_to"});
    endtask

    // Output checker: scoreboard pops plus thermometer/ready invariants every cycle
    always @(negedge clk) begin
        logic [NR-1:0] inv;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, obs_of(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
        if (cyc > 0) begin
            inv = ~rst_out;
            chk("thermo", 32'((inv & (inv + NR'(1))) == '0), 32'd1);
            chk("ready_inv", 32'(ready), 32'(rst_out == '0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k, m, s, r2, c, t;
        reset_n      = 1'b0;
        pll_unlocked = 1'b1;

        // reset state and power-up PLL reset pulse
        push_reset_vals(4, "por");
        wait_cyc(3);
        wait_cyc(4);
        reset_n = 1'b1;
        w = 20;
        push(w - 1, SEL_REQ, 1, "req_pwrup_hi");
        push(w,     SEL_REQ, 0, "req_pwrup_lo");
        push(w,     SEL_RST, 7, "rst_wait");
        push(w,     SEL_RDY, 0, "rdy_wait");

        // lock timeouts: re-pulse every 1040 cycles, timeout_cnt 1,2,3
        for (int i = 0; i < 3; i++) begin
            t = w + i * 1040 + 1024;
            push(t - 1,  SEL_REQ, 0,     "to_req_pre");
            push(t - 1,  SEL_TO,  i,     "to_cnt_pre");
            push(t,      SEL_REQ, 1,     "to_req_hi");
            push(t,      SEL_TO,  i + 1, "to_cnt");
            push(t + 15, SEL_REQ, 1,     "to_req_last");
            push(t + 16, SEL_REQ, 0,     "to_req_lo");
        end

        // lock acquisition and staggered release
        k = w + 3 * 1040 + 6;
        push(k + 65, SEL_RST, 7, "rel0_pre");
        push(k + 66, SEL_RST, 6, "rel0");
        push(k + 73, SEL_RST, 6, "rel1_pre");
        push(k + 74, SEL_RST, 4, "rel1");
        push(k + 81, SEL_RDY, 0, "rdy_pre");
        push(k + 82, SEL_RST, 0, "rel2");
        push(k + 82, SEL_RDY, 1, "rdy_run");
        push(k + 82, SEL_TO,  3, "to_hold");
        wait_cyc(k - 1);
        pll_unlocked = 1'b0;

        // one-cycle lock loss in RUN
        m = k + 91;
        push(m + 1, SEL_RST, 0, "run_loss_pre");
        push(m + 1, SEL_RDY, 1, "run_loss_rdy_pre");
        push(m + 2, SEL_RST, 7, "run_loss_rst");
        push(m + 2, SEL_RDY, 0, "run_loss_rdy");
        push(m + 2, SEL_LL,  1, "run_loss_ll");
        // glitch at STABLE cnt=40 restarts qualification without counting
        s = m + 3;
        push(s + 64,  SEL_RST, 7, "glitch_norel");
        push(s + 105, SEL_RST, 7, "glitch_rel_pre");
        push(s + 106, SEL_RST, 6, "glitch_rel");
        push(s + 106, SEL_LL,  1, "glitch_ll");
        // loss between rst_out[0] and rst_out[1] release
        push(s + 109, SEL_RST, 6, "rel_loss_pre");
        push(s + 110, SEL_RST, 7, "rel_loss_rst");
        push(s + 110, SEL_RDY, 0, "rel_loss_rdy");
        push(s + 110, SEL_LL,  2, "rel_loss_ll");
        push(s + 175, SEL_RST, 6, "rerel0");
        push(s + 183, SEL_RST, 4, "rerel1");
        push(s + 185, SEL_LL,  2, "mid_ll");
        push(s + 185, SEL_TO,  3, "mid_to");
        push_reset_vals(s + 186, "midrst");

        wait_cyc(k + 90);
        pll_unlocked = 1'b1;
        wait_cyc(m);
        pll_unlocked = 1'b0;
        wait_cyc(s + 38);
        pll_unlocked = 1'b1;
        wait_cyc(s + 39);
        pll_unlocked = 1'b0;
        wait_cyc(s + 107);
        pll_unlocked = 1'b1;
        wait_cyc(s + 108);
        pll_unlocked = 1'b0;
        wait_cyc(s + 185);
        reset_n = 1'b0;

        // lock-loss counter saturation
        r2 = s + 187;
        push(r2 + 97, SEL_RDY, 1, "sat_run");
        wait_cyc(r2);
        reset_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            c = r2 + 100 + i * 90;
            push(c + 2, SEL_RDY, 1, "sat_rdy_pre");
            push(c + 3, SEL_RST, 7, "sat_rst");
            push(c + 3, SEL_LL, (i + 1 > 255) ? 255 : i + 1, "sat_ll");
            wait_cyc(c);
            pll_unlocked = 1'b1;
            wait_cyc(c + 1);
            pll_unlocked = 1'b0;
        end
        wait_cyc(c + 100);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
